// File: rtl/mem_access_unit.sv
// MEM-stage data access unit: turns the latched EX/MEM access into a single
// request/response bus transaction, stalls the pipeline until it completes,
// extends load data and owns the LL/SC link state.
// Optional watchdog abort is built when MEM_TIMEOUT_EN is defined.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        valid_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        mem_re_in,
  input  logic [3:0]  ram_we_in,
  input  logic [2:0]  ram_ext_op_in,
  input  logic        ll_in,
  input  logic        sc_in,
  input  logic        flush_in,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        suspend_out,
  output logic        done_out,
  output logic [31:0] load_data_out,
  output logic        sc_result_out,
  output logic        addr_err_out,
  output logic        bus_err_out
);

  typedef enum logic [1:0] {StIdle = 2'd0, StReq = 2'd1, StWait = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        we_q, we_d;
  logic [2:0]  ext_q, ext_d;
  logic        ll_q, ll_d;
  logic        sc_q, sc_d;
  logic        llbit_q, llbit_d;
  logic [29:0] link_addr_q, link_addr_d;

  logic        acc, mis, link_hit, sc_fail, timeout;
  logic        ld_word, ld_half, st_word, st_half;
  logic [31:0] rshift, ext_data;

  // Ext op only describes loads; stores are sized purely by the byte mask.
  assign acc      = valid_in & (mem_re_in | (|ram_we_in));
  assign ld_word  = mem_re_in & (ram_ext_op_in == 3'd0);
  assign ld_half  = mem_re_in & ((ram_ext_op_in == 3'd3) | (ram_ext_op_in == 3'd4));
  assign st_word  = (ram_we_in == 4'b1111);
  assign st_half  = (ram_we_in == 4'b0011);
  assign mis      = ((ld_half | st_half) & addr_in[0]) |
                    ((ld_word | st_word) & (addr_in[1:0] != 2'b00));
  assign link_hit = llbit_q & (link_addr_q == addr_in[31:2]);
  assign sc_fail  = sc_in & ~link_hit;

  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_we    = we_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Cycles spent in REQ/WAIT; held at zero while idle so every access starts fresh.
  always_comb begin
    cnt_d = '0;
    if (state_q != StIdle) cnt_d = cnt_q + 1'b1;
  end

  // Watchdog counter register.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Align the addressed lane down to bit 0, then sign/zero extend.
  always_comb begin
    rshift = bus_rdata >> {addr_q[1:0], 3'b000};
    case (ext_q)
      3'd1:    ext_data = {{24{rshift[7]}}, rshift[7:0]};
      3'd2:    ext_data = {24'h0, rshift[7:0]};
      3'd3:    ext_data = {{16{rshift[15]}}, rshift[15:0]};
      3'd4:    ext_data = {16'h0, rshift[15:0]};
      default: ext_data = rshift;
    endcase
  end

  // Next-state, link bookkeeping and all handshake outputs.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    we_d          = we_q;
    ext_d         = ext_q;
    ll_d          = ll_q;
    sc_d          = sc_q;
    llbit_d       = llbit_q;
    link_addr_d   = link_addr_q;
    bus_req       = 1'b0;
    suspend_out   = 1'b0;
    done_out      = 1'b0;
    load_data_out = 32'h0;
    sc_result_out = 1'b0;
    addr_err_out  = 1'b0;
    bus_err_out   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (valid_in & (~acc | mis | sc_fail)) begin
          // Non-memory, misaligned or doomed SC: retire without touching the bus.
          done_out     = 1'b1;
          addr_err_out = mis & acc;
        end else if (acc) begin
          suspend_out = 1'b1;
          addr_d      = addr_in;
          wdata_d     = wdata_in << {addr_in[1:0], 3'b000};
          wstrb_d     = ram_we_in << addr_in[1:0];
          we_d        = |ram_we_in;
          ext_d       = ram_ext_op_in;
          ll_d        = ll_in;
          sc_d        = sc_in;
          state_d     = StReq;
        end
      end
      StReq, StWait: begin
        suspend_out = 1'b1;
        if (bus_rvalid & ((state_q == StWait) | bus_gnt)) begin
          // Completion: pipeline advances on this edge.
          bus_req       = (state_q == StReq);
          suspend_out   = 1'b0;
          done_out      = 1'b1;
          load_data_out = ext_data;
          sc_result_out = sc_q;
          state_d       = StIdle;
          if (ll_q) begin
            llbit_d     = 1'b1;
            link_addr_d = addr_q[31:2];
          end
          if (we_q & (sc_q | (addr_q[31:2] == link_addr_q))) llbit_d = 1'b0;
        end else if (timeout) begin
          // Abort; request is withheld so no grant can start a stray transfer.
          suspend_out = 1'b0;
          done_out    = 1'b1;
          bus_err_out = 1'b1;
          llbit_d     = 1'b0;
          state_d     = StIdle;
        end else if (state_q == StReq) begin
          bus_req = 1'b1;
          if (bus_gnt) state_d = StWait;
        end
      end
      default: state_d = StIdle;
    endcase

    if (flush_in) llbit_d = 1'b0;

    // Outputs read as zero for as long as reset is held.
    if (cpu_rst) begin
      bus_req       = 1'b0;
      suspend_out   = 1'b0;
      done_out      = 1'b0;
      load_data_out = 32'h0;
      sc_result_out = 1'b0;
      addr_err_out  = 1'b0;
      bus_err_out   = 1'b0;
    end
  end

  // State and latched-access registers.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q     <= StIdle;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      we_q        <= 1'b0;
      ext_q       <= 3'd0;
      ll_q        <= 1'b0;
      sc_q        <= 1'b0;
      llbit_q     <= 1'b0;
      link_addr_q <= 30'h0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      we_q        <= we_d;
      ext_q       <= ext_d;
      ll_q        <= ll_d;
      sc_q        <= sc_d;
      llbit_q     <= llbit_d;
      link_addr_q <= link_addr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of single-cycle retire cases
// plus hand-written multi-cycle bus sequences. Timeout checks need MEM_TIMEOUT_EN.
module tb_mem_access_unit;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        valid_in, mem_re_in, ll_in, sc_in, flush_in;
  logic [31:0] addr_in, wdata_in;
  logic [3:0]  ram_we_in;
  logic [2:0]  ram_ext_op_in;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;
  logic        suspend_out, done_out, sc_result_out, addr_err_out, bus_err_out;
  logic [31:0] load_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rst       (cpu_rst),
    .valid_in      (valid_in),
    .addr_in       (addr_in),
    .wdata_in      (wdata_in),
    .mem_re_in     (mem_re_in),
    .ram_we_in     (ram_we_in),
    .ram_ext_op_in (ram_ext_op_in),
    .ll_in         (ll_in),
    .sc_in         (sc_in),
    .flush_in      (flush_in),
    .bus_req       (bus_req),
    .bus_addr      (bus_addr),
    .bus_we        (bus_we),
    .bus_wstrb     (bus_wstrb),
    .bus_wdata     (bus_wdata),
    .bus_gnt       (bus_gnt),
    .bus_rvalid    (bus_rvalid),
    .bus_rdata     (bus_rdata),
    .suspend_out   (suspend_out),
    .done_out      (done_out),
    .load_data_out (load_data_out),
    .sc_result_out (sc_result_out),
    .addr_err_out  (addr_err_out),
    .bus_err_out   (bus_err_out)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic        valid;
    logic [31:0] addr;
    logic        re;
    logic [3:0]  we;
    logic [2:0]  ext;
    logic        sc;
    logic [3:0]  exp; // {done, suspend, bus_req, addr_err}
  } vec_t;

  typedef struct packed {
    int          susp;
    logic        req;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [3:0]  bstrb;
    logic        bwe;
    logic [31:0] ld;
    logic        scr;
    logic        aerr;
    logic        berr;
    logic        done;
  } res_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in      = 1'b0;
    addr_in       = 32'h0;
    wdata_in      = 32'h0;
    mem_re_in     = 1'b0;
    ram_we_in     = 4'h0;
    ram_ext_op_in = 3'd0;
    ll_in         = 1'b0;
    sc_in         = 1'b0;
    flush_in      = 1'b0;
  endtask

  // Present one access and act as the bus slave: grant as soon as a request is
  // seen, respond rvd cycles after the grant (rvd < 0: never respond).
  task automatic run_access(input logic [31:0] a, input logic [31:0] wd, input logic re,
                            input logic [3:0] we, input logic [2:0] ext, input logic ll,
                            input logic sc, input logic fl, input int rvd,
                            input logic [31:0] rd, output res_t r);
    int   gcyc;
    logic granted;
    r       = '0;
    granted = 1'b0;
    gcyc    = 0;
    @(posedge cpu_clk); #1;
    valid_in      = 1'b1;
    addr_in       = a;
    wdata_in      = wd;
    mem_re_in     = re;
    ram_we_in     = we;
    ram_ext_op_in = ext;
    ll_in         = ll;
    sc_in         = sc;
    flush_in      = fl;
    bus_rdata     = rd;
    for (int k = 0; k < 40; k++) begin
      @(negedge cpu_clk);
      bus_rvalid = 1'b0;
      if (bus_req && !granted) begin
        bus_gnt = 1'b1;
        granted = 1'b1;
        gcyc    = k;
      end else begin
        bus_gnt = 1'b0;
      end
      if (granted && rvd >= 0 && (k - gcyc) == rvd) bus_rvalid = 1'b1;
      #1;
      if (bus_req) begin
        r.req    = 1'b1;
        r.baddr  = bus_addr;
        r.bwdata = bus_wdata;
        r.bstrb  = bus_wstrb;
        r.bwe    = bus_we;
      end
      if (suspend_out) r.susp++;
      if (done_out) begin
        r.done = 1'b1;
        r.ld   = load_data_out;
        r.scr  = sc_result_out;
        r.aerr = addr_err_out;
        r.berr = bus_err_out;
        break;
      end
    end
    @(posedge cpu_clk); #1;
    idle_inputs();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
  endtask

  task automatic flush_pulse();
    @(posedge cpu_clk); #1;
    flush_in = 1'b1;
    @(posedge cpu_clk); #1;
    flush_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    vec_t vecs[8];
    res_t r;

    vecs[0] = '{1'b0, 32'h4000, 1'b0, 4'b0000, 3'd0, 1'b0, 4'b0000}; // idle
    vecs[1] = '{1'b1, 32'h4000, 1'b0, 4'b0000, 3'd0, 1'b0, 4'b1000}; // non-memory
    vecs[2] = '{1'b1, 32'h4002, 1'b1, 4'b0000, 3'd0, 1'b0, 4'b1001}; // LW misaligned
    vecs[3] = '{1'b1, 32'h4001, 1'b1, 4'b0000, 3'd3, 1'b0, 4'b1001}; // LH odd
    vecs[4] = '{1'b1, 32'h4003, 1'b1, 4'b0000, 3'd4, 1'b0, 4'b1001}; // LHU odd
    vecs[5] = '{1'b1, 32'h4003, 1'b0, 4'b0011, 3'd0, 1'b0, 4'b1001}; // SH odd
    vecs[6] = '{1'b1, 32'h4001, 1'b0, 4'b1111, 3'd0, 1'b0, 4'b1001}; // SW misaligned
    vecs[7] = '{1'b1, 32'h4000, 1'b0, 4'b1111, 3'd0, 1'b1, 4'b1000}; // SC without link

    // Reset with a live non-memory entry: everything must still read zero.
    idle_inputs();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    cpu_rst    = 1'b1;
    valid_in   = 1'b1;
    #1;
    check("reset_ctrl", {24'h0, bus_req, bus_we, suspend_out, done_out, sc_result_out,
                         addr_err_out, bus_err_out, 1'b0}, 32'h0);
    check("reset_data", load_data_out | bus_addr | bus_wdata | {28'h0, bus_wstrb}, 32'h0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < 8; i++) begin
      @(posedge cpu_clk); #1;
      valid_in      = vecs[i].valid;
      addr_in       = vecs[i].addr;
      mem_re_in     = vecs[i].re;
      ram_we_in     = vecs[i].we;
      ram_ext_op_in = vecs[i].ext;
      sc_in         = vecs[i].sc;
      @(negedge cpu_clk);
      check($sformatf("vec%0d", i), {28'h0, done_out, suspend_out, bus_req, addr_err_out},
            {28'h0, vecs[i].exp});
    end
    @(posedge cpu_clk); #1;
    idle_inputs();

    // LB signed at byte 3, response two cycles after grant.
    run_access(32'h1003, 32'h0, 1'b1, 4'h0, 3'd1, 1'b0, 1'b0, 1'b0, 2, 32'h80FF_FF12, r);
    check("lb_done", {31'h0, r.done}, 32'h1);
    check("lb_addr", r.baddr, 32'h1000);
    check("lb_we", {31'h0, r.bwe}, 32'h0);
    check("lb_susp", r.susp, 32'd3);
    check("lb_data", r.ld, 32'hFFFF_FF80);

    run_access(32'h1001, 32'h0, 1'b1, 4'h0, 3'd2, 1'b0, 1'b0, 1'b0, 1, 32'h80FF_FF12, r);
    check("lbu_data", r.ld, 32'h0000_00FF);
    run_access(32'h1002, 32'h0, 1'b1, 4'h0, 3'd3, 1'b0, 1'b0, 1'b0, 1, 32'h80FF_FF12, r);
    check("lh_data", r.ld, 32'hFFFF_80FF);
    run_access(32'h1000, 32'h0, 1'b1, 4'h0, 3'd4, 1'b0, 1'b0, 1'b0, 1, 32'h80FF_FF12, r);
    check("lhu_data", r.ld, 32'h0000_FF12);

    // Grant and response in the same REQ cycle.
    run_access(32'h1000, 32'h0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 0, 32'h80FF_FF12, r);
    check("lw_fast_data", r.ld, 32'h80FF_FF12);
    check("lw_fast_susp", r.susp, 32'd1);

    // Stores: lane shift and strobes.
    run_access(32'h2002, 32'h0000_ABCD, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0, 1'b0, 1, 32'h0, r);
    check("sh_done", {31'h0, r.done}, 32'h1);
    check("sh_strb", {28'h0, r.bstrb}, 32'hC);
    check("sh_wdata", r.bwdata, 32'hABCD_0000);
    check("sh_we", {31'h0, r.bwe}, 32'h1);
    check("sh_addr", r.baddr, 32'h2000);
    run_access(32'h2001, 32'h0000_005A, 1'b0, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1, 32'h0, r);
    check("sb_strb", {28'h0, r.bstrb}, 32'h2);
    check("sb_wdata", r.bwdata, 32'h0000_5A00);

    // LL then SC succeeds once, second SC fails without touching the bus.
    run_access(32'h3000, 32'h0, 1'b1, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1, 32'h1, r);
    run_access(32'h3000, 32'h7, 1'b0, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 1, 32'h0, r);
    check("sc1_req", {31'h0, r.req}, 32'h1);
    check("sc1_result", {31'h0, r.scr}, 32'h1);
    run_access(32'h3000, 32'h7, 1'b0, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 1, 32'h0, r);
    check("sc2_req_done_susp", {29'h0, r.req, r.done, r.susp[0]}, 32'h2);
    check("sc2_result", {31'h0, r.scr}, 32'h0);

    // Store to a different word keeps the link.
    run_access(32'h3000, 32'h0, 1'b1, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1, 32'h1, r);
    run_access(32'h3004, 32'h9, 1'b0, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 1, 32'h0, r);
    run_access(32'h3000, 32'h7, 1'b0, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 1, 32'h0, r);
    check("sc_other_store", {30'h0, r.req, r.scr}, 32'h3);

    // Store to the linked word breaks it.
    run_access(32'h3000, 32'h0, 1'b1, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1, 32'h1, r);
    run_access(32'h3004, 32'h9, 1'b0, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 1, 32'h0, r);
    run_access(32'h3000, 32'h9, 1'b0, 4'hF, 3'd0, 1'b0, 1'b0, 1'b0, 1, 32'h0, r);
    run_access(32'h3000, 32'h7, 1'b0, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 1, 32'h0, r);
    check("sc_after_store", {29'h0, r.done, r.req, r.scr}, 32'h4);

    // Flush between LL and SC.
    run_access(32'h3000, 32'h0, 1'b1, 4'h0, 3'd0, 1'b1, 1'b0, 1'b0, 1, 32'h1, r);
    flush_pulse();
    run_access(32'h3000, 32'h7, 1'b0, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 1, 32'h0, r);
    check("sc_after_flush", {29'h0, r.done, r.req, r.scr}, 32'h4);

    // Flush coinciding with the LL completion wins over the set.
    run_access(32'h3000, 32'h0, 1'b1, 4'h0, 3'd0, 1'b1, 1'b0, 1'b1, 1, 32'h1, r);
    run_access(32'h3000, 32'h7, 1'b0, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0, 1, 32'h0, r);
    check("sc_flush_with_ll", {29'h0, r.done, r.req, r.scr}, 32'h4);

    // Stray response while idle is ignored.
    @(posedge cpu_clk); #1;
    bus_rvalid = 1'b1;
    @(negedge cpu_clk);
    check("stray_rvalid", {30'h0, done_out, suspend_out}, 32'h0);
    @(posedge cpu_clk); #1;
    bus_rvalid = 1'b0;

    // Reset while waiting for a response.
    @(posedge cpu_clk); #1;
    valid_in  = 1'b1;
    addr_in   = 32'h5000;
    mem_re_in = 1'b1;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    check("wait_req", {31'h0, bus_req}, 32'h1);
    bus_gnt = 1'b1;
    @(posedge cpu_clk); #1;
    bus_gnt = 1'b0;
    @(negedge cpu_clk);
    check("wait_stall", {30'h0, suspend_out, bus_req}, 32'h2);
    cpu_rst = 1'b1;
    #1;
    check("rst_wait_ctrl", {25'h0, bus_req, bus_we, suspend_out, done_out, sc_result_out,
                            addr_err_out, bus_err_out}, 32'h0);
    check("rst_wait_data", load_data_out | bus_addr, 32'h0);
    @(negedge cpu_clk);
    cpu_rst = 1'b0;
    idle_inputs();
    run_access(32'h5004, 32'h0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 32'hCAFE_F00D, r);
    check("post_rst_load", r.ld, 32'hCAFE_F00D);

`ifdef MEM_TIMEOUT_EN
    // Bus grants but never answers: abort after 8 cycles in REQ/WAIT.
    run_access(32'h6000, 32'h0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, -1, 32'h1234_5678, r);
    check("to_done", {30'h0, r.done, r.berr}, 32'h3);
    check("to_susp", r.susp, 32'd8);
    check("to_data", r.ld, 32'h0);
    @(posedge cpu_clk); #1;
    bus_rvalid = 1'b1;
    @(negedge cpu_clk);
    check("to_late_rvalid", {29'h0, done_out, suspend_out, bus_err_out}, 32'h0);
    @(posedge cpu_clk); #1;
    bus_rvalid = 1'b0;
    run_access(32'h6004, 32'h0, 1'b1, 4'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1, 32'h0000_BEEF, r);
    check("to_recover", r.ld, 32'h0000_BEEF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched access (address, store data, byte mask, extension op, LL/SC flags) into a request/response transaction on the data bus.
- Stalls the pipeline through `suspend_out` until the access completes.
- Returns extended load data and the SC result toward MEM/WB, and owns the LL/SC link state.

Parameters:
- TIMEOUT_CYCLES, 256: watchdog limit in cycles; used only when MEM_TIMEOUT_EN is defined.

Ports:
- cpu_clk  input  1  clock
- cpu_rst  input  1  reset; asynchronous, active-high
- valid_in  input  1  EX/MEM entry valid
- addr_in  input  32  effective address (EX/MEM alu_C)
- wdata_in  input  32  store data (EX/MEM rD2), unshifted
- mem_re_in  input  1  load instruction
- ram_we_in  input  4  lane-0 store size mask: 0001 byte, 0011 half, 1111 word; 0000 means not a store
- ram_ext_op_in  input  3  load op: 0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned
- ll_in  input  1  LL instruction
- sc_in  input  1  SC instruction
- flush_in  input  1  exception/ERET; clears link bit
- bus_req  output  1  request valid
- bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}
- bus_we  output  1  write request
- bus_wstrb  output  4  byte strobes
- bus_wdata  output  32  lane-shifted store data
- bus_gnt  input  1  request accepted
- bus_rvalid  input  1  response (read data or write ack)
- bus_rdata  input  32  read data
- suspend_out  output  1  stall to EX/MEM and earlier stages
- done_out  output  1  current EX/MEM entry completes this cycle
- load_data_out  output  32  extended load result; valid when done_out=1
- sc_result_out  output  1  SC success; valid when done_out=1
- addr_err_out  output  1  misaligned access; pulse with done_out
- bus_err_out  output  1  watchdog abort; pulse with done_out

Behaviour:
- Reset values:
  - state IDLE, llbit=0, link_addr=0, watchdog counter=0.
  - All outputs 0.
  - Reset mid-transaction abandons the access; there is no bus cleanup.
- Access classification:
  - `acc = valid_in & (mem_re_in | |ram_we_in)`.
  - `mis`:
    - half access (mask 0011 or ext 3/4) with addr[0]=1;
    - word access with addr[1:0]≠0.
  - `sc_fail = sc_in & !(llbit & link_addr==addr_in[31:2])`.
- Immediate completion (IDLE only, 0 latency, combinational):
  - valid_in & (!acc | mis | sc_fail) gives done_out=1 and suspend_out=0.
  - addr_err_out = mis & acc.
  - sc_result_out=0.
  - No bus request is made.
- States:
  - IDLE:
    - acc & !mis & !sc_fail: suspend_out=1 the same cycle; register addr, lane-shifted wdata, strobes = ram_we_in<<addr[1:0], and we = |ram_we_in; go to REQ.
  - REQ:
    - bus_req=1, address/data held stable, suspend_out=1.
    - bus_gnt gives WAIT.
  - WAIT:
    - bus_req=0.
    - Without bus_rvalid: suspend_out=1.
    - With bus_rvalid:
      - done_out=1, suspend_out=0 (the pipeline advances at this edge); go to IDLE.
      - load_data_out = bus_rdata shifted right by 8·addr[1:0], then sign- or zero-extended per the registered ext_op.
      - sc_result_out = registered sc flag.
- Single-cycle response: bus_gnt and bus_rvalid high in the same REQ cycle is legal. It completes exactly as WAIT+rvalid does, one cycle earlier.
- Link state:
  - A completed LL load sets llbit=1 and link_addr=addr[31:2].
  - A completed successful SC clears llbit.
  - Any completed store whose word address equals link_addr clears llbit.
  - flush_in clears llbit. flush_in has priority over an LL set in the same cycle.
- Bus protocol: bus_rvalid outside WAIT (or outside the REQ same-cycle case) is ignored. Only one transaction is outstanding at a time.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - Counter cleared on entry to REQ; increments in REQ and WAIT.
  - Reaching TIMEOUT_CYCLES without completion gives done_out=1, bus_err_out=1, load_data_out=32'h0, sc_result_out=0, llbit cleared, return to IDLE.
  - A late bus_rvalid after the abort is ignored.
- Undefined: no counter; bus_err_out is tied 0; the unit waits indefinitely.

Test Plan:
- LB: addr 0x1003, ext 1, bus_rdata 0x80FF_FF12, 2-cycle rvalid → bus_addr 0x1000, suspend high 3 cycles, load_data_out 0xFFFF_FF80 with done_out.
- SH: addr 0x2002, mask 0011, wdata 0x0000_ABCD → bus_wstrb 1100, bus_wdata 0xABCD_xxxx in the upper half, bus_we=1, done_out on ack.
- LL 0x3000 then SC 0x3000 → bus write issued, sc_result_out=1, llbit 0 afterward; a second SC 0x3000 → no bus_req, done same cycle, sc_result_out=0.
- LL 0x3000, SW 0x3004, SW 0x3000, SC 0x3000 → SC fails. Repeat with flush_in between the LL and the SC → SC fails.
- LW 0x4002 → addr_err_out=1, done_out=1, no bus_req, suspend_out=0. Non-memory valid_in → done_out same cycle, no stall.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, bus never responds → bus_err_out pulse after 8 cycles, then IDLE. Assert cpu_rst while in WAIT → all outputs 0 immediately.
